// File: rtl/ov7670_pkg.sv
// Shared constants and types for the OV7670 camera capture path.
package ov7670_pkg;

  localparam int unsigned DEF_H_PIXELS    = 640;
  localparam int unsigned DEF_V_LINES     = 480;
  localparam int unsigned DEF_ADDR_WIDTH  = 19;
  localparam int unsigned DEF_PIXEL_WIDTH = 4;
  localparam int unsigned FRAME_WORDS     = DEF_H_PIXELS * DEF_V_LINES;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACTIVE    = 1'b1
  } cap_state_t;

endpackage

// File: rtl/rgb565_to_gray4.sv
// Combinational RGB565 to 4-bit grey: (R5 + 2*G6[5:1] + B5) / 8.
module rgb565_to_gray4 (
  input  logic [15:0] rgb_i,
  output logic [3:0]  gray_o
);

  logic [6:0] sum;
  logic       unused_g_lsb;

  // G6[0] is dropped so green carries the same 5-bit weight as red and blue
  assign unused_g_lsb = rgb_i[5];

  always_comb begin
    sum    = 7'(rgb_i[15:11]) + 7'(rgb_i[10:6]) + 7'(rgb_i[10:6]) + 7'(rgb_i[4:0]);
    gray_o = sum[6:3];
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 byte-stream capture; writes 4-bit grey pixels to a linear frame buffer.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_PIXELS    = DEF_H_PIXELS,
  parameter int unsigned V_LINES     = DEF_V_LINES,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [7:0]             cam_data,
  output logic [ADDR_WIDTH-1:0]  frame_addr,
  output logic [PIXEL_WIDTH-1:0] frame_pixel,
  output logic                   frame_we,
  output logic                   frame_done
);

  localparam int unsigned XW = $clog2(H_PIXELS + 1);
  localparam int unsigned YW = $clog2(V_LINES + 1);

  cap_state_t             state_q, state_d;
  logic                   phase_q, phase_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
  logic [7:0]             hi_byte_q, hi_byte_d;
  logic                   vsync_q, href_q;
  logic [ADDR_WIDTH-1:0]  frame_addr_q, frame_addr_d;
  logic [PIXEL_WIDTH-1:0] frame_pixel_q, frame_pixel_d;
  logic                   frame_we_q, frame_we_d;
  logic                   frame_done_q, frame_done_d;

  logic       vsync_rise, vsync_fall, href_fall;
  logic [3:0] gray;

  rgb565_to_gray4 u_gray (
    .rgb_i  ({hi_byte_q, cam_data}),
    .gray_o (gray)
  );

  assign vsync_rise = ~vsync_q & cam_vsync;
  assign vsync_fall = vsync_q & ~cam_vsync;
  assign href_fall  = href_q & ~cam_href;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    hi_byte_d     = hi_byte_q;
    frame_addr_d  = frame_addr_q;
    frame_pixel_d = frame_pixel_q;
    frame_we_d    = 1'b0;
    frame_done_d  = 1'b0;

    unique case (state_q)
      WAIT_SYNC: begin
        if (vsync_fall) begin
          state_d     = ACTIVE;
          phase_d     = 1'b0;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
        end
      end
      ACTIVE: begin
        // vsync rise takes priority over any byte or href edge on the same cycle
        if (vsync_rise) begin
          state_d      = WAIT_SYNC;
          phase_d      = 1'b0;
          frame_done_d = 1'b1;
        end else if (href_fall) begin
          phase_d = 1'b0;
          if (x_q != '0 && y_q < YW'(V_LINES)) begin
            y_d         = y_q + 1'b1;
            line_base_d = line_base_q + ADDR_WIDTH'(H_PIXELS);
          end
          x_d = '0;
        end else if (cam_href) begin
          if (!phase_q) begin
            hi_byte_d = cam_data;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < XW'(H_PIXELS) && y_q < YW'(V_LINES)) begin
              frame_we_d    = 1'b1;
              frame_addr_d  = line_base_q + ADDR_WIDTH'(x_q);
              frame_pixel_d = PIXEL_WIDTH'(gray);
            end
            // x saturates at H_PIXELS: further pixels on the line are discarded anyway
            if (x_q < XW'(H_PIXELS)) begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_SYNC;
      phase_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      hi_byte_q     <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      frame_addr_q  <= '0;
      frame_pixel_q <= '0;
      frame_we_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      hi_byte_q     <= hi_byte_d;
      vsync_q       <= cam_vsync;
      href_q        <= cam_href;
      frame_addr_q  <= frame_addr_d;
      frame_pixel_q <= frame_pixel_d;
      frame_we_q    <= frame_we_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign frame_addr  = frame_addr_q;
  assign frame_pixel = frame_pixel_q;
  assign frame_we    = frame_we_q;
  assign frame_done  = frame_done_q;

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera-side writer for the shared frame buffer; the VGA scan-out reads the same buffer at 25 MHz.
- Samples the OV7670 parallel bus (VSYNC/HREF/D[7:0], RGB565, 2 bytes per pixel) on pclk.
- Converts each pixel to 4-bit grey and writes it at linear address y*H_PIXELS + x, which matches the 4-bit pixel / 19-bit address scan-out format.
- Runs in the pclk domain; the buffer is true dual-port, so no CDC inside this block.

Parameters:
- H_PIXELS, 640, pixels per line written; pixel x >= H_PIXELS is discarded.
- V_LINES, 480, lines per frame written; line y >= V_LINES is discarded.
- ADDR_WIDTH, 19, frame_addr width.
- PIXEL_WIDTH, 4, frame_pixel width.

Ports:
- pclk, input, 1, camera pixel clock; all logic on rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- cam_vsync, input, 1, frame sync, high during vertical blanking.
- cam_href, input, 1, high while line bytes are valid.
- cam_data, input, 8, pixel byte.
- frame_addr, output, ADDR_WIDTH, write address.
- frame_pixel, output, PIXEL_WIDTH, grey write data.
- frame_we, output, 1, one-cycle write strobe per pixel.
- frame_done, output, 1, one-cycle pulse when an ACTIVE frame ends.

Behaviour:
- Interface: one clock, pclk; reset rst is asynchronous and active-high.
- Reset values:
  - frame_addr = 0, frame_pixel = 0, frame_we = 0, frame_done = 0.
  - State = WAIT_SYNC; phase, x, y, line_base, vsync_d, href_d all 0.
- vsync_d and href_d are 1-cycle registered copies, used for edge detection.
- WAIT_SYNC:
  - All bytes ignored.
  - vsync falling edge (vsync_d=1, cam_vsync=0) -> ACTIVE, with x=0, y=0, line_base=0, phase=0.
  - Effect: after reset, capture always starts at a frame boundary.
- ACTIVE, cam_href=1, phase=0: latch cam_data into hi_byte; phase<=1.
- ACTIVE, cam_href=1, phase=1: form pixel {hi_byte, cam_data} = R5 G6 B5; phase<=0.
  - If x < H_PIXELS and y < V_LINES, next cycle: frame_we=1, frame_addr=line_base+x, frame_pixel=grey.
  - x increments regardless of whether the write happens.
  - Write latency: frame_we asserts 1 cycle after the second byte is sampled.
- Grey arithmetic: g = (R5 + G6[5:1] + G6[5:1] + B5), 7-bit unsigned, max 124; frame_pixel = g[6:3]. Examples:
  - White 0xFFFF -> 15.
  - Black 0x0000 -> 0.
  - Pure green 0x07E0 -> 7.
- href falling edge (href_d=1, cam_href=0), in ACTIVE:
  - phase<=0; a dangling odd byte is dropped.
  - If x != 0: y<=y+1 and line_base<=line_base+H_PIXELS (saturates once y >= V_LINES, no wrap).
  - x<=0.
- Short lines (x < H_PIXELS at href fall) leave the remaining addresses of that line unwritten; the next line still starts at line_base+H_PIXELS.
- vsync rising edge in ACTIVE:
  - frame_done pulses 1 cycle; state -> WAIT_SYNC.
  - This applies even mid-line: the partial line is abandoned and phase is cleared.
- Simultaneous events:
  - vsync rise with a second byte on the same cycle: vsync wins; no write.
  - href fall with vsync rise: vsync handling only.
- Writes never exceed address H_PIXELS*V_LINES-1 (307199 at defaults). frame_addr holds its last value when frame_we=0.
- Reset mid-frame: outputs clear immediately and no further writes occur until the next vsync falling edge.

Decomposition:
- ov7670_pkg:
  - H_PIXELS/V_LINES defaults and ADDR_WIDTH.
  - State enum cap_state_t {WAIT_SYNC, ACTIVE}.
  - Constant FRAME_WORDS = H_PIXELS*V_LINES.
- One combinational sub-module, rgb565_to_gray4 (16-bit in, 4-bit out). It is reused by any later preview/LeNet crop path.

Test Plan:
- Reset then bytes with cam_href=1 before any vsync -> frame_we stays 0. Vsync pulse 1->0, then bytes FF,FF -> frame_we at addr 0, pixel 15, one cycle after the 2nd byte.
- Line of 640 pixels 0x07E0, href low, second line of 2 pixels 0xF800 -> addresses 0..639 written with pixel 7; then 640 (pixel 3) and 641 (pixel 3).
- Line of 700 pixels -> only addresses 0..639 written; next line starts at 640.
- Line of 5 bytes (odd) -> 2 writes; 5th byte dropped; next line pixel at line_base 640, x=0.
- 481 full lines -> last write at 307199; line 481 produces no frame_we. Vsync rise -> frame_done exactly 1 cycle.
- rst asserted mid-line (async, between pclk edges) -> outputs 0 immediately; after release, no writes until a vsync falling edge; next frame restarts at addr 0.
